// File: rtl/adjmat_writer.sv
// ============================================================================
//  Module   : adjmat_writer
//  Brief    : Edge-update writer for the Bellman-Ford adjacency matrix; commits
//             a batch, pulses the solver start and freezes the matrix per run.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module adjmat_writer #(
    parameter int          NODES = 16,
    parameter logic [31:0] INF   = 32'h0000FFFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            upd_valid,
    output logic                            upd_ready,
    input  logic [6:0]                      upd_src,
    input  logic [6:0]                      upd_dst,
    input  logic [31:0]                     upd_weight,
    input  logic                            upd_last,
    input  logic [6:0]                      src_sel,
    output logic                            bf_start,
    output logic [6:0]                      bf_src,
    input  logic                            bf_done,
    output logic [NODES:0][NODES:0][31:0]   adjmat,
    output logic                            busy,
    output logic [15:0]                     drop_count,
    output logic [15:0]                     run_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [6:0] c_NODE_MAX = 7'(NODES);

    state_t                          r_state_q,      w_state_d;
    logic                            r_bf_start_q,   w_bf_start_d;
    logic [6:0]                      r_bf_src_q,     w_bf_src_d;
    logic                            r_busy_q,       w_busy_d;
    logic [15:0]                     r_drop_count_q, w_drop_count_d;
    logic [15:0]                     r_run_count_q,  w_run_count_d;
    logic [NODES:0][NODES:0][31:0]   r_adjmat_q,     w_adjmat_d;

    logic        w_upd_ready;
    logic        w_beat;
    logic        w_edge_ok;
    logic [31:0] w_weight_sx;
    logic        w_unused_weight_hi;

    function automatic logic [NODES:0][NODES:0][31:0] f_init_matrix();
        logic [NODES:0][NODES:0][31:0] m;
        for (int i = 0; i <= NODES; i++) begin
            for (int j = 0; j <= NODES; j++) begin
                m[i][j] = (i == j) ? 32'd0 : INF;
            end
        end
        return m;
    endfunction

    assign w_upd_ready        = (r_state_q == ST_IDLE);
    assign w_beat             = upd_valid && w_upd_ready;
    assign w_edge_ok          = (upd_src <= c_NODE_MAX) && (upd_dst <= c_NODE_MAX)
                                && (upd_src != upd_dst);
    assign w_weight_sx        = {{15{upd_weight[16]}}, upd_weight[16:0]};
    assign w_unused_weight_hi = ^upd_weight[31:17];

    always_comb begin
        w_state_d      = r_state_q;
        w_bf_start_d   = 1'b0;
        w_bf_src_d     = r_bf_src_q;
        w_busy_d       = r_busy_q;
        w_drop_count_d = r_drop_count_q;
        w_run_count_d  = r_run_count_q;
        w_adjmat_d     = r_adjmat_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_beat) begin
                    if (w_edge_ok) begin
                        for (int i = 0; i <= NODES; i++) begin
                            for (int j = 0; j <= NODES; j++) begin
                                if (upd_src == 7'(i) && upd_dst == 7'(j)) begin
                                    w_adjmat_d[i][j] = w_weight_sx;
                                end
                            end
                        end
                    end else if (r_drop_count_q != 16'hFFFF) begin
                        w_drop_count_d = r_drop_count_q + 16'd1;
                    end
                    // A rejected beat still commits the batch when it is last.
                    if (upd_last) begin
                        w_state_d    = ST_START;
                        w_bf_start_d = 1'b1;
                        w_bf_src_d   = src_sel;
                        w_busy_d     = 1'b1;
                    end
                end
            end
            ST_START: begin
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bf_done) begin
                    w_state_d     = ST_IDLE;
                    w_busy_d      = 1'b0;
                    w_run_count_d = r_run_count_q + 16'd1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_bf_start_q   <= 1'b0;
            r_bf_src_q     <= 7'd0;
            r_busy_q       <= 1'b0;
            r_drop_count_q <= 16'd0;
            r_run_count_q  <= 16'd0;
            r_adjmat_q     <= f_init_matrix();
        end else begin
            r_state_q      <= w_state_d;
            r_bf_start_q   <= w_bf_start_d;
            r_bf_src_q     <= w_bf_src_d;
            r_busy_q       <= w_busy_d;
            r_drop_count_q <= w_drop_count_d;
            r_run_count_q  <= w_run_count_d;
            r_adjmat_q     <= w_adjmat_d;
        end
    end

    assign upd_ready  = w_upd_ready;
    assign bf_start   = r_bf_start_q;
    assign bf_src     = r_bf_src_q;
    assign busy       = r_busy_q;
    assign drop_count = r_drop_count_q;
    assign run_count  = r_run_count_q;
    assign adjmat     = r_adjmat_q;

endmodule

`default_nettype wire

// File: tb/tb_adjmat_writer.sv
// ============================================================================
//  Module   : tb_adjmat_writer
//  Brief    : Self-checking bench for adjmat_writer against a behavioural model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adjmat_writer;

    localparam int          N   = 16;
    localparam logic [31:0] INF = 32'h0000FFFF;

    logic                       clk        = 1'b0;
    logic                       reset      = 1'b1;
    logic                       upd_valid  = 1'b0;
    logic                       upd_last   = 1'b0;
    logic                       bf_done    = 1'b0;
    logic [6:0]                 upd_src    = 7'd0;
    logic [6:0]                 upd_dst    = 7'd0;
    logic [6:0]                 src_sel    = 7'd0;
    logic [31:0]                upd_weight = 32'd0;
    logic                       upd_ready;
    logic                       bf_start;
    logic                       busy;
    logic [6:0]                 bf_src;
    logic [15:0]                drop_count;
    logic [15:0]                run_count;
    logic [N:0][N:0][31:0]      adjmat;

    adjmat_writer #(.NODES(N), .INF(INF)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_src    (upd_src),
        .upd_dst    (upd_dst),
        .upd_weight (upd_weight),
        .upd_last   (upd_last),
        .src_sel    (src_sel),
        .bf_start   (bf_start),
        .bf_src     (bf_src),
        .bf_done    (bf_done),
        .adjmat     (adjmat),
        .busy       (busy),
        .drop_count (drop_count),
        .run_count  (run_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Behavioural model: matrix as a plain array, run phase as idle/start/wait.
    logic [31:0] m_mat [0:N][0:N];
    int          m_phase = 0;
    int          m_drops = 0;
    int          m_runs  = 0;
    logic [6:0]  m_src   = 7'd0;
    bit          m_live  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= N; i++)
                for (int j = 0; j <= N; j++)
                    m_mat[i][j] = (i == j) ? 32'd0 : INF;
            m_phase = 0; m_drops = 0; m_runs = 0; m_src = 7'd0; m_live = 1'b1;
        end else if (m_phase == 0) begin
            if (upd_valid) begin
                if (int'(upd_src) <= N && int'(upd_dst) <= N && upd_src != upd_dst)
                    m_mat[upd_src][upd_dst] = int'($signed(upd_weight[16:0]));
                else if (m_drops < 65535)
                    m_drops++;
                if (upd_last) begin
                    m_phase = 1;
                    m_src   = src_sel;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (bf_done) begin
            m_phase = 0;
            m_runs  = (m_runs + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        int nbad;
        int bi, bj;
        if (m_live) begin
            check("upd_ready",  32'(upd_ready),  32'(m_phase == 0));
            check("bf_start",   32'(bf_start),   32'(m_phase == 1));
            check("busy",       32'(busy),       32'(m_phase != 0));
            check("bf_src",     32'(bf_src),     32'(m_src));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            check("run_count",  32'(run_count),  32'(m_runs));
            nbad = 0; bi = 0; bj = 0;
            for (int i = 0; i <= N; i++)
                for (int j = 0; j <= N; j++)
                    if (adjmat[i][j] !== m_mat[i][j]) begin
                        if (nbad == 0) begin bi = i; bj = j; end
                        nbad++;
                    end
            n_checks++;
            if (nbad == 0) n_pass++;
            else $display("FAIL adjmat[%0d][%0d]: actual %h required %h (%0d cells differ)",
                          bi, bj, adjmat[bi][bj], m_mat[bi][bj], nbad);
        end
    end

    // Matrix must be bit-stable for the whole time busy is high.
    logic [N:0][N:0][31:0] snap;
    int unstable = 0;
    always @(negedge clk) begin
        if (bf_start) snap = adjmat;
        else if (busy && adjmat !== snap) unstable++;
    end

    // Solver stand-in: answers a start pulse after a latency.
    bit auto_solver = 1'b1;
    int fixed_lat   = 0;
    int sol_lat;
    always begin
        @(negedge clk);
        if (auto_solver && bf_start) begin
            sol_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
            repeat (sol_lat) @(posedge clk);
            #1 bf_done = 1'b1;
            @(posedge clk);
            #1 bf_done = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int d, input logic [31:0] w, input bit last, input int sel);
        bit r;
        int g;
        g = 0;
        upd_valid = 1'b1; upd_src = 7'(s); upd_dst = 7'(d);
        upd_weight = w; upd_last = last; src_sel = 7'(sel);
        do begin
            @(negedge clk);
            r = upd_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!r && g < 400);
        if (!r) begin
            n_checks++;
            $display("FAIL send_timeout: actual not accepted required accepted");
        end
        upd_valid = 1'b0; upd_last = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!upd_ready && g < 400);
        if (!upd_ready) begin
            n_checks++;
            $display("FAIL idle_timeout: actual busy required idle");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        int pulses;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_diag",  adjmat[3][3], 32'd0);
        check("rst_off",   adjmat[3][4], 32'h0000FFFF);
        check("rst_ready", 32'(upd_ready), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_drop",  32'(drop_count), 32'd0);
        tick();

        // Overwrite then commit; solver answers 40 cycles after start.
        fixed_lat = 40;
        send(2, 5, 32'hA5A3FFFE, 1'b0, 0);
        send(2, 5, 32'h7F000010, 1'b1, 3);
        @(negedge clk);
        check("w25_last_wins", adjmat[2][5], 32'h00000010);
        check("start_pulse",   32'(bf_start), 32'd1);
        check("start_src",     32'(bf_src), 32'd3);
        pulses = 1; waited = 0;
        while (!upd_ready && waited < 200) begin
            @(negedge clk);
            if (bf_start) pulses++;
            if (!upd_ready) waited++;
        end
        check("start_one_cycle", 32'(pulses), 32'd1);
        check("wait_cycles",     32'(waited), 32'd40);
        check("run_count_1",     32'(run_count), 32'd1);
        tick();
        fixed_lat = 0;

        send(0, 1, 32'hDEC1FFFF, 1'b0, 0);
        @(negedge clk);
        check("sext_minus1", adjmat[0][1], 32'hFFFFFFFF);
        tick();

        // Three rejected beats; the last still commits.
        send(4, 4, 32'h1111, 1'b0, 0);
        send(N + 1, 0, 32'h2222, 1'b0, 0);
        send(0, 127, 32'h3333, 1'b1, 0);
        @(negedge clk);
        check("drop_3",       32'(drop_count), 32'd3);
        check("drop_start",   32'(bf_start), 32'd1);
        check("drop_no_write", adjmat[4][5], INF);
        wait_idle();

        // Beat held during the run is consumed only once idle again.
        fixed_lat = 20;
        send(1, 2, 32'h77, 1'b1, 5);
        send(3, 7, 32'h00001234, 1'b0, 0);
        @(negedge clk);
        check("held_write", adjmat[3][7], 32'h00001234);
        check("stable_busy", 32'(unstable), 32'd0);
        tick();
        fixed_lat = 0;

        // Reset in the middle of a run; a late done is ignored.
        auto_solver = 1'b0;
        send(6, 7, 32'h42, 1'b1, 2);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_wait_cell",  adjmat[6][7], INF);
        check("rst_wait_ready", 32'(upd_ready), 32'd1);
        repeat (10) tick();
        bf_done = 1'b1;
        tick();
        bf_done = 1'b0;
        @(negedge clk);
        check("late_done_runs", 32'(run_count), 32'd0);
        check("late_done_busy", 32'(busy), 32'd0);
        tick();

        // Reset wins over a beat in the same cycle.
        upd_valid = 1'b1; upd_src = 7'd8; upd_dst = 7'd9;
        upd_weight = 32'h55; upd_last = 1'b1; src_sel = 7'd1;
        reset = 1'b1;
        tick();
        reset = 1'b0; upd_valid = 1'b0; upd_last = 1'b0;
        @(negedge clk);
        check("rst_beat_cell", adjmat[8][9], INF);
        check("rst_beat_busy", 32'(busy), 32'd0);
        tick();

        // Randomized traffic.
        auto_solver = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int s, d;
            s = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, N + 2));
            d = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, N + 2));
            send(s, d, $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(0, N)));
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_idle();
        check("stable_final", 32'(unstable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
